// File: rtl/cache_bus_pkg.sv
// Shared types and constants for the cache-to-memory line bus.
package cache_bus_pkg;

    localparam int unsigned DEF_ADDR_W = 32;
    localparam int unsigned DEF_LINE_W = 128;

    // Channel indices as wired at the core boundary.
    localparam int unsigned CH_ICACHE  = 0;
    localparam int unsigned CH_DREFILL = 1;
    localparam int unsigned CH_DWB     = 2;

    typedef enum logic [1:0] {
        StIdle = 2'd0,
        StBusy = 2'd1,
        StResp = 2'd2
    } arb_state_e;

endpackage

// File: rtl/rr_pick.sv
// Winner selection for the memory-port arbiter: fixed-priority or round-robin.
module rr_pick #(
    parameter int unsigned NUM_CH    = 3,
    parameter int unsigned PRIO_MODE = 1
) (
    input  logic [NUM_CH-1:0]         req_i,
    input  logic [$clog2(NUM_CH)-1:0] last_grant_i,
    output logic [$clog2(NUM_CH)-1:0] winner_o,
    output logic                      valid_o
);
    localparam int unsigned GW = $clog2(NUM_CH);

    logic [GW-1:0] lo_idx;
    logic [GW-1:0] hi_idx;
    logic          hi_found;

    // lo_idx: lowest requester overall; hi_idx: lowest requester above last_grant.
    // Round-robin takes hi_idx when present, otherwise wraps to lo_idx.
    always_comb begin
        lo_idx   = '0;
        hi_idx   = '0;
        hi_found = 1'b0;
        for (int i = NUM_CH - 1; i >= 0; i--) begin
            if (req_i[i]) begin
                lo_idx = GW'(i);
                if (GW'(i) > last_grant_i) begin
                    hi_idx   = GW'(i);
                    hi_found = 1'b1;
                end
            end
        end
        if (PRIO_MODE == 0) begin
            winner_o = lo_idx;
        end else begin
            winner_o = hi_found ? hi_idx : lo_idx;
        end
        valid_o = |req_i;
    end

endmodule

// File: rtl/cache_mem_arbiter.sv
// Shares one line-wide memory port among NUM_CH cache channels, one transaction at a time.
module cache_mem_arbiter
    import cache_bus_pkg::*;
#(
    parameter int unsigned NUM_CH    = 3,
    parameter int unsigned ADDR_W    = DEF_ADDR_W,
    parameter int unsigned LINE_W    = DEF_LINE_W,
    parameter int unsigned PRIO_MODE = 1
) (
    input  logic                        clk,
    input  logic                        rst_n,
    input  logic [NUM_CH-1:0]           ch_req_i,
    input  logic [NUM_CH-1:0]           ch_we_i,
    input  logic [NUM_CH*ADDR_W-1:0]    ch_addr_i,
    input  logic [NUM_CH*LINE_W-1:0]    ch_wdata_i,
    output logic [NUM_CH-1:0]           ch_ready_o,
    output logic [LINE_W-1:0]           ch_rdata_o,
    output logic                        mem_req_o,
    output logic                        mem_we_o,
    output logic [ADDR_W-1:0]           mem_addr_o,
    output logic [LINE_W-1:0]           mem_wdata_o,
    input  logic                        mem_ready_i,
    input  logic [LINE_W-1:0]           mem_rdata_i,
    output logic [$clog2(NUM_CH)-1:0]   grant_o,
    output logic                        busy_o
);
    localparam int unsigned GW = $clog2(NUM_CH);

    arb_state_e        state_q;
    logic [GW-1:0]     grant_q;
    logic [GW-1:0]     last_grant_q;
    logic              we_q;
    logic              mem_req_q;
    logic [ADDR_W-1:0] addr_q;
    logic [LINE_W-1:0] wdata_q;
    logic [LINE_W-1:0] rdata_q;
    logic [NUM_CH-1:0] ready_q;

    logic [GW-1:0]     pick;
    logic              pick_valid;
    logic              sel_we;
    logic [ADDR_W-1:0] sel_addr;
    logic [LINE_W-1:0] sel_wdata;
    logic [NUM_CH-1:0] grant_onehot;

    rr_pick #(
        .NUM_CH    (NUM_CH),
        .PRIO_MODE (PRIO_MODE)
    ) u_pick (
        .req_i        (ch_req_i),
        .last_grant_i (last_grant_q),
        .winner_o     (pick),
        .valid_o      (pick_valid)
    );

    // Steer the winning channel's direction, address and line onto the capture bus.
    always_comb begin
        sel_we    = 1'b0;
        sel_addr  = '0;
        sel_wdata = '0;
        for (int i = 0; i < NUM_CH; i++) begin
            if (pick == GW'(i)) begin
                sel_we    = ch_we_i[i];
                sel_addr  = ch_addr_i[i*ADDR_W +: ADDR_W];
                sel_wdata = ch_wdata_i[i*LINE_W +: LINE_W];
            end
        end
    end

    // One-hot form of the registered grant, used for the completion pulse.
    always_comb begin
        grant_onehot = '0;
        for (int i = 0; i < NUM_CH; i++) begin
            grant_onehot[i] = (grant_q == GW'(i));
        end
    end

    // Arbitration FSM; every output is a register so reset clears them at once.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q      <= StIdle;
            grant_q      <= '0;
            last_grant_q <= GW'(NUM_CH - 1);
            we_q         <= 1'b0;
            mem_req_q    <= 1'b0;
            addr_q       <= '0;
            wdata_q      <= '0;
            rdata_q      <= '0;
            ready_q      <= '0;
        end else begin
            unique case (state_q)
                StIdle: begin
                    if (pick_valid) begin
                        grant_q      <= pick;
                        last_grant_q <= pick;
                        we_q         <= sel_we;
                        addr_q       <= sel_addr;
                        wdata_q      <= sel_wdata;
                        mem_req_q    <= 1'b1;
                        state_q      <= StBusy;
                    end
                end
                StBusy: begin
                    if (mem_ready_i) begin
                        mem_req_q <= 1'b0;
                        // Writes leave the last read line visible on ch_rdata_o.
                        if (!we_q) begin
                            rdata_q <= mem_rdata_i;
                        end
                        ready_q <= grant_onehot;
                        state_q <= StResp;
                    end
                end
                StResp: begin
                    ready_q <= '0;
                    state_q <= StIdle;
                end
                default: begin
                    mem_req_q <= 1'b0;
                    ready_q   <= '0;
                    state_q   <= StIdle;
                end
            endcase
        end
    end

    assign ch_ready_o  = ready_q;
    assign ch_rdata_o  = rdata_q;
    assign mem_req_o   = mem_req_q;
    assign mem_we_o    = we_q;
    assign mem_addr_o  = addr_q;
    assign mem_wdata_o = wdata_q;
    assign grant_o     = grant_q;
    assign busy_o      = (state_q != StIdle);

endmodule

// File: doc/cache_mem_arbiter.md
CACHE_MEM_ARBITER -- requirements
Module: cache_mem_arbiter

Interface
REQ-001 Parameter NUM_CH, default 3: number of requesting cache channels, 2..8 (0 = Icache refill, 1 = Dcache refill, 2 = Dcache writeback).
REQ-002 Parameter ADDR_W, default 32: byte-address width.
REQ-003 Parameter LINE_W, default 128: cache-line width in bits, a multiple of 32.
REQ-004 Parameter PRIO_MODE, default 1: 0 = fixed priority (lowest index wins), 1 = round-robin.
REQ-005 clk  in  1  single clock; all state changes on the rising edge.
REQ-006 rst_n  in  1  reset, asynchronous, active-low.
REQ-007 ch_req_i  in  NUM_CH  per-channel request level; held high until that channel's ready pulse.
REQ-008 ch_we_i  in  NUM_CH  per-channel direction: 1 = line write, 0 = line read.
REQ-009 ch_addr_i  in  NUM_CH*ADDR_W  flattened line addresses; channel k occupies bits [k*ADDR_W +: ADDR_W].
REQ-010 ch_wdata_i  in  NUM_CH*LINE_W  flattened write lines, sliced the same way as ch_addr_i.
REQ-011 ch_ready_o  out  NUM_CH  one-cycle completion pulse per channel.
REQ-012 ch_rdata_o  out  LINE_W  shared read line; valid while the matching ch_ready_o bit is high.
REQ-013 mem_req_o, mem_we_o  out  1 each  memory-port request and direction.
REQ-014 mem_addr_o  out  ADDR_W  memory-port address.
REQ-015 mem_wdata_o  out  LINE_W  memory-port write line.
REQ-016 mem_ready_i  in  1  memory-port completion.
REQ-017 mem_rdata_i  in  LINE_W  memory-port read line; valid with mem_ready_i.
REQ-018 grant_o  out  $clog2(NUM_CH)  index of the channel currently granted.
REQ-019 busy_o  out  1  high in any state other than IDLE.

Function
REQ-020 The FSM SHALL have three states (IDLE, BUSY, RESP) and reset to IDLE.
REQ-021 IDLE with any ch_req_i bit high SHALL, on that edge: select a winner, register its index, we, addr and wdata, and move to BUSY.
REQ-022 PRIO_MODE=0 SHALL pick the lowest-index requesting channel.
REQ-023 PRIO_MODE=1 SHALL pick the first requesting channel after last_grant, searching upward with wrap from NUM_CH-1 to 0.
REQ-024 last_grant SHALL update on each grant; its reset value is NUM_CH-1, so channel 0 is favoured first.
REQ-025 In BUSY, mem_req_o SHALL be 1 and mem_we_o, mem_addr_o, mem_wdata_o SHALL hold the registered values, unchanged until mem_ready_i.
REQ-026 BUSY with mem_ready_i=1 SHALL, on that edge, move to RESP and capture mem_rdata_i into ch_rdata_o; the capture is skipped for write transactions.
REQ-027 In RESP, ch_ready_o[grant] SHALL be 1 and all other bits 0; the next state is IDLE unconditionally.
REQ-028 Minimum latency SHALL be: ch_req_i at cycle 0, mem_req_o at cycle 1, ch_ready_o at cycle 2 (with mem_ready_i at cycle 1); each arbitration takes at least 3 cycles.
REQ-029 mem_ready_i in IDLE or RESP SHALL be ignored.
REQ-030 Changes to ch_req_i, ch_addr_i or ch_wdata_i after grant SHALL NOT affect the transaction in flight.
REQ-031 Multiple simultaneous requests SHALL be served one per arbitration, with no channel lost.
REQ-032 Under PRIO_MODE=1, with every channel requesting continuously, each channel SHALL be granted once per NUM_CH transactions.
REQ-033 Outside BUSY, mem_req_o SHALL be 0 and mem_addr_o, mem_wdata_o, mem_we_o SHALL hold their last values.

Reset
REQ-034 While rst_n=0, all outputs SHALL be 0 immediately, independent of clk; this includes ch_rdata_o and grant_o.
REQ-035 Assertion of rst_n mid-transaction SHALL abandon the transaction and return to IDLE with last_grant=NUM_CH-1; no ready pulse is issued.
REQ-036 After rst_n is released, the first arbitration SHALL occur on the first rising edge at which any ch_req_i bit is high.

Structure
REQ-037 Package cache_bus_pkg SHALL hold the FSM state encoding, the default LINE_W/ADDR_W constants and the channel-index constants (CH_ICACHE=0, CH_DREFILL=1, CH_DWB=2).
REQ-038 A combinational sub-module rr_pick SHALL compute the winner from the request vector, last_grant and PRIO_MODE; all registers live in cache_mem_arbiter.

Verification
REQ-039 Setup: NUM_CH=3, PRIO_MODE=1. ch_req_i=001 read, addr 0x0000_1000, memory returns line 0x...DEADBEEF with a 4-cycle delay -> ch_ready_o=001 exactly once, ch_rdata_o=0x...DEADBEEF, mem_addr_o=0x0000_1000 throughout BUSY.
REQ-040 ch_req_i=111 held, each channel dropping its request after its ready pulse -> grant order 0, 1, 2; 9 cycles total with a 1-cycle memory.
REQ-041 Same stimulus as REQ-040 with PRIO_MODE=0 and channel 0 re-requesting immediately -> channel 0 always wins; channel 2 is served only once channel 0 is idle.
REQ-042 Channel 2 write, addr 0x80, wdata 0xA5 repeated, with ch_wdata_i changed during BUSY -> mem_wdata_o stays 0xA5 repeated, mem_we_o=1, ch_rdata_o unchanged from the previous read.
REQ-043 rst_n pulsed low in BUSY -> mem_req_o falls within the same cycle, no ch_ready_o pulse, and the next grant goes to channel 0.
